// File: rtl/phase_acc_pkg.sv
// Shared widths, FSM encoding and dither LFSR constants for the phase accumulator.
// PSZ lives here so the sine stage and the accumulator stay width-locked.
package phase_acc_pkg;

  localparam int unsigned PA_ASZ = 32;
  localparam int unsigned PA_PSZ = 12;

  localparam logic [15:0] PA_LFSR_SEED = 16'hACE1;
  // Feedback taps for x^16 + x^15 + x^13 + x^4 + 1
  localparam logic [15:0] PA_LFSR_TAPS = 16'hD008;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pa_state_e;

endpackage

// File: rtl/phase_acc_dither.sv
// 16-bit maximal-length Fibonacci LFSR used to dither the truncated phase.
// Only built when PHASE_DITHER_EN is defined; otherwise no dither logic exists.
`ifdef PHASE_DITHER_EN
module phs_dither_lfsr
  import phase_acc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] out
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR value: shift in the tap parity while enabled
  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & PA_LFSR_TAPS)};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= PA_LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out = lfsr_q;

endmodule
`endif

// File: rtl/phase_acc.sv
// NCO phase accumulator with valid/ready shadowed config, applied phase-continuously.
// Optional output dither via PHASE_DITHER_EN (instantiates phs_dither_lfsr).
module phase_acc
  import phase_acc_pkg::*;
#(
  parameter int unsigned    ASZ  = PA_ASZ,
  parameter int unsigned    PSZ  = PA_PSZ,
  parameter logic [ASZ-1:0] FRST = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [ASZ-1:0] cfg_freq,
  input  logic [PSZ-1:0] cfg_poff,
  input  logic           cfg_sync,
  output logic [PSZ-1:0] phs,
  output logic           phs_valid,
  output logic           wrap
);

  pa_state_e      state_q, state_d;
  logic [ASZ-1:0] acc_q, acc_d;
  logic [ASZ-1:0] freq_q, freq_d;
  logic [PSZ-1:0] poff_q, poff_d;
  logic           rdy_q, rdy_d;
  logic           ovf_q, ovf_d;
  logic [ASZ-1:0] sh_freq_q;
  logic [PSZ-1:0] sh_poff_q;
  logic           sh_sync_q;
  logic [PSZ-1:0] phs_q, phs_d;
  logic           vld_q, vld_d;
  logic           wrap_q, wrap_d;

  logic           hs_s;
  logic           apply_s;
  logic           active_s;
  logic [ASZ:0]   sum_s;
  logic [ASZ-1:0] dacc_s;

  assign hs_s     = cfg_valid & rdy_q;
  // A not-ready port always means a shadow word waiting to be applied this cycle
  assign apply_s  = ~rdy_q;
  assign active_s = (state_q == ST_RUN) & run;
  assign sum_s    = {1'b0, acc_q} + {1'b0, freq_q};

`ifdef PHASE_DITHER_EN
  localparam int unsigned DW    = ASZ - PSZ;
  localparam logic [15:0] DMASK = (DW >= 32'd16) ? 16'hFFFF : 16'((32'd1 << DW) - 32'd1);
  logic [15:0]    lfsr_s;
  logic [ASZ-1:0] dith_s;

  phs_dither_lfsr u_dither (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == ST_RUN),
    .out   (lfsr_s)
  );

  assign dith_s = ASZ'(lfsr_s & DMASK);
  assign dacc_s = acc_q + dith_s;
`else
  assign dacc_s = acc_q;
`endif

  // Run/idle state transitions; run deassertion takes effect immediately
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_RUN;
        else     state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (!run) state_d = ST_IDLE;
        else      state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Accumulator, config apply and output-stage next values
  always_comb begin
    freq_d = freq_q;
    poff_d = poff_q;
    rdy_d  = rdy_q;
    acc_d  = '0;
    ovf_d  = 1'b0;

    if (apply_s) begin
      freq_d = sh_freq_q;
      poff_d = sh_poff_q;
      rdy_d  = 1'b1;
    end else if (hs_s) begin
      rdy_d  = 1'b0;
    end else begin
      rdy_d  = rdy_q;
    end

    // Outside an active run the accumulator is held at zero, so sync is moot there
    if (active_s) begin
      if (apply_s && sh_sync_q) begin
        acc_d = '0;
        ovf_d = 1'b0;
      end else begin
        acc_d = sum_s[ASZ-1:0];
        ovf_d = sum_s[ASZ];
      end
    end else begin
      acc_d = '0;
      ovf_d = 1'b0;
    end

    phs_d  = dacc_s[ASZ-1 -: PSZ] + poff_q;
    vld_d  = (state_q == ST_RUN);
    wrap_d = ovf_q & (state_q == ST_RUN);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      freq_q  <= FRST;
      poff_q  <= '0;
      rdy_q   <= 1'b1;
      ovf_q   <= 1'b0;
      phs_q   <= '0;
      vld_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      freq_q  <= freq_d;
      poff_q  <= poff_d;
      rdy_q   <= rdy_d;
      ovf_q   <= ovf_d;
      phs_q   <= phs_d;
      vld_q   <= vld_d;
      wrap_q  <= wrap_d;
    end
  end

  // Shadow config captured on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_freq_q <= '0;
      sh_poff_q <= '0;
      sh_sync_q <= 1'b0;
    end else if (hs_s) begin
      sh_freq_q <= cfg_freq;
      sh_poff_q <= cfg_poff;
      sh_sync_q <= cfg_sync;
    end else begin
      sh_freq_q <= sh_freq_q;
      sh_poff_q <= sh_poff_q;
      sh_sync_q <= sh_sync_q;
    end
  end

  assign cfg_ready = rdy_q;
  assign phs       = phs_q;
  assign phs_valid = vld_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_phase_acc.sv
// Directed-vector bench for phase_acc (ASZ=16, PSZ=12, dither off).
module tb_phase_acc;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_freq;
  logic [11:0] cfg_poff;
  logic        cfg_sync;
  logic [11:0] phs;
  logic        phs_valid;
  logic        wrap;

  int n_cmp = 0;
  int n_err = 0;
  int n_xfer;

  phase_acc #(.ASZ(16), .PSZ(12), .FRST(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_freq  (cfg_freq),
    .cfg_poff  (cfg_poff),
    .cfg_sync  (cfg_sync),
    .phs       (phs),
    .phs_valid (phs_valid),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_word(input logic [15:0] f, input logic [11:0] p, input logic s);
    cfg_valid = 1'b1;
    cfg_freq  = f;
    cfg_poff  = p;
    cfg_sync  = s;
  endtask

  // Expected phs after each of four ticks following a freq change at phs 0x500
  logic [11:0] exp_chg  [4] = '{12'h600, 12'h700, 12'h800, 12'h880};
  logic [11:0] exp_b2b  [6] = '{12'h580, 12'h600, 12'h680, 12'h780, 12'h880, 12'hA80};
  logic        rdy_b2b  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [11:0] exp_half [5] = '{12'h000, 12'h800, 12'h000, 12'h800, 12'h000};
  logic        wrp_half [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0; run = 1'b0; cfg_valid = 1'b0;
    cfg_freq = 16'h0000; cfg_poff = 12'h000; cfg_sync = 1'b0;
    tick(); tick();
    chk_eq("rst_phs", 32'(phs), 32'h0);
    chk_eq("rst_vld", 32'(phs_valid), 32'h0);
    chk_eq("rst_wrap", 32'(wrap), 32'h0);
    chk_eq("rst_rdy", 32'(cfg_ready), 32'h1);
    rst_n = 1'b1;
    tick();

    // Load freq 0x1000 while idle
    cfg_word(16'h1000, 12'h000, 1'b0);
    tick();
    chk_eq("idle_cfg_rdy_lo", 32'(cfg_ready), 32'h0);
    cfg_valid = 1'b0;
    tick();
    chk_eq("idle_cfg_rdy_hi", 32'(cfg_ready), 32'h1);

    // Start: first valid sample at the 2nd edge
    run = 1'b1;
    tick();
    chk_eq("start_vld0", 32'(phs_valid), 32'h0);
    tick();
    chk_eq("start_vld1", 32'(phs_valid), 32'h1);
    chk_eq("start_phs", 32'(phs), 32'h0);
    for (int k = 1; k <= 21; k++) begin
      tick();
      chk_eq("ramp_phs", 32'(phs), 32'((k * 256) % 4096));
      chk_eq("ramp_wrap", 32'(wrap), (k % 16 == 0) ? 32'h1 : 32'h0);
    end

    // Phase-continuous freq change to 0x0800 at phs 0x500
    cfg_word(16'h0800, 12'h000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      cfg_valid = 1'b0;
      chk_eq("chg_phs", 32'(phs), 32'(exp_chg[i]));
      chk_eq("chg_rdy", 32'(cfg_ready), (i == 0) ? 32'h0 : 32'h1);
    end
    tick();
    chk_eq("chg_phs_step", 32'(phs), 32'h900);

    // Sync with offset 0x400: next sample restarts at the offset
    cfg_word(16'h0800, 12'h400, 1'b1);
    tick();
    cfg_valid = 1'b0;
    chk_eq("sync_hs_phs", 32'(phs), 32'h980);
    tick();
    chk_eq("sync_apply_phs", 32'(phs), 32'hA00);
    tick();
    chk_eq("sync_phs0", 32'(phs), 32'h400);
    tick();
    chk_eq("sync_phs1", 32'(phs), 32'h480);
    tick();
    chk_eq("sync_phs2", 32'(phs), 32'h500);
    cfg_sync = 1'b0;

    // cfg_valid held 4 clks: two transfers, second one 2 clks after the first
    n_xfer = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 2)      cfg_word(16'h1000, 12'h400, 1'b0);
      else if (i < 4) cfg_word(16'h2000, 12'h400, 1'b0);
      else            cfg_valid = 1'b0;
      if (cfg_valid && cfg_ready) n_xfer++;
      tick();
      chk_eq("b2b_phs", 32'(phs), 32'(exp_b2b[i]));
      chk_eq("b2b_rdy", 32'(cfg_ready), 32'(rdy_b2b[i]));
    end
    chk_eq("b2b_xfers", 32'(n_xfer), 32'd2);

    // run dropped for one clk
    run = 1'b0;
    tick();
    run = 1'b1;
    chk_eq("drop_vld_last", 32'(phs_valid), 32'h1);
    chk_eq("drop_phs_last", 32'(phs), 32'hC80);
    tick();
    chk_eq("drop_vld_gap", 32'(phs_valid), 32'h0);
    tick();
    chk_eq("drop_vld_back", 32'(phs_valid), 32'h1);
    chk_eq("drop_phs_restart", 32'(phs), 32'h400);
    tick();
    chk_eq("drop_phs_next", 32'(phs), 32'h600);

    // Half-scale frequency: phs alternates, wrap on every 2nd sample
    cfg_word(16'h8000, 12'h000, 1'b1);
    tick();
    cfg_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_eq("half_phs", 32'(phs), 32'(exp_half[i]));
      chk_eq("half_wrap", 32'(wrap), 32'(wrp_half[i]));
    end
    cfg_sync = 1'b0;

    // Async reset with a config pending: pending word must be lost
    cfg_word(16'h1234, 12'h000, 1'b0);
    tick();
    cfg_valid = 1'b0;
    chk_eq("pend_rdy_lo", 32'(cfg_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("arst_rdy", 32'(cfg_ready), 32'h1);
    chk_eq("arst_phs", 32'(phs), 32'h0);
    chk_eq("arst_vld", 32'(phs_valid), 32'h0);
    chk_eq("arst_wrap", 32'(wrap), 32'h0);
    run = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    tick();
    chk_eq("post_rst_rdy", 32'(cfg_ready), 32'h1);
    run = 1'b1;
    tick();
    tick();
    chk_eq("post_rst_vld", 32'(phs_valid), 32'h1);
    chk_eq("post_rst_phs0", 32'(phs), 32'h0);
    tick();
    tick();
    chk_eq("freq0_phs_const", 32'(phs), 32'h0);
    chk_eq("freq0_no_wrap", 32'(wrap), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
